pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC controller for the 16-bit fetch stage. It drives the PC register's data input and freeze enable. It arbitrates between sequential increment, branch redirect, hazard stall, instruction-memory wait and halt, and it flushes the IF/ID latch whenever a fetched instruction must be discarded. A redirect that arrives while instruction memory is still busy is held until the fetch completes.

## Interface
- RESET_PC, 16'h0000, PC value presented after reset.
- PC_STEP, 2, byte increment per sequential fetch.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- pc_cur  in  16  current PC register output.
- imem_valid  in  1  instruction memory returned the word at pc_cur this cycle.
- stall  in  1  hazard unit requests that the PC hold.
- br_taken  in  1  branch/jump resolved taken this cycle.
- br_target  in  16  redirect address. Bit 0 is ignored.
- halt_dec  in  1  HLT opcode decoded.
- pc_next  out  16  value for the PC register input.
- pc_freeze  out  1  PC register write inhibit, 1 = hold.
- flush  out  1  squash the IF/ID latch contents at the next edge.
- fetch_req  out  1  instruction memory read request for pc_cur.
- halted  out  1  core stopped.

## Operation
- Internal registers:
  - state: BOOT, RUN, WAIT, HALT.
  - redir_pend, 1 bit.
  - redir_pc, 16 bits.
- All outputs are combinational from these registers and the current inputs.
- Redirect value is {target[15:1],1'b0}. Sequential value is pc_cur+PC_STEP mod 2^16, so FFFE wraps to 0000.
- Priority in every state: halt_dec > redirect > stall > memory wait > increment.
- BOOT (reset state), held for one cycle after rst deasserts:
  - Outputs: pc_next=RESET_PC, pc_freeze=0, flush=1, fetch_req=0, halted=0.
  - Next state: RUN.
- RUN, fetch_req=1:
  - halt_dec: freeze=1, flush=1, go to HALT, clear redir_pend.
  - br_taken with imem_valid=1: pc_next=redirect, freeze=0, flush=1. br_taken overrides stall.
  - br_taken with imem_valid=0: freeze=1, latch redir_pc, set redir_pend, go to WAIT.
  - stall with no redirect: freeze=1, flush=0, stay in RUN.
  - imem_valid=0: freeze=1, go to WAIT.
  - Otherwise: pc_next=pc_cur+PC_STEP, freeze=0, flush=0.
- WAIT, fetch_req=1, freeze=1 while imem_valid=0:
  - br_taken latches redir_pc; the latest target wins.
  - halt_dec goes to HALT and drops any pending redirect.
  - On imem_valid=1, the redirect source is br_taken if asserted this cycle, else redir_pend.
    - With a redirect: pc_next=redirect, freeze=0, flush=1, clear redir_pend.
    - Else with stall: freeze=1.
    - Else: increment.
  - Return to RUN.
- HALT:
  - Outputs: freeze=1, flush=0, fetch_req=0, halted=1.
  - All inputs ignored. Exit only via rst.
- Reset asserted in any state returns to BOOT at once and clears redir_pend and redir_pc.

## Timing
- Input-to-output paths are combinational within the same cycle. The PC register captures pc_next at the next rising edge, so a redirect appears on pc_cur one cycle after br_taken.
- State and redirect registers update on the rising clk edge. Reset acts immediately, without waiting for clk.
- halted rises in the cycle after halt_dec is sampled.
- The pending-redirect capture costs no extra cycle: the redirect takes effect in the same cycle imem_valid rises.
- No combinational path from pc_cur to freeze or flush.

## Structure
- Shared cpu_pkg holds:
  - the state enum;
  - PC_WIDTH=16, RESET_PC, PC_STEP;
  - the redirect alignment mask 16'hFFFE.
- One sub-module, pc_incr: a 16-bit PC_STEP incrementer that wraps mod 2^16.
- The FSM, redirect latch and output mux live in pc_sequencer.

## Test plan
- Reset and boot: rst=0, then release with pc_cur=0000 and imem_valid=1.
  - During reset: pc_next=0000, flush=1, fetch_req=0.
  - Next cycle: RUN with pc_next=0002, freeze=0.
- Wrap: RUN with pc_cur=FFFE and imem_valid=1 -> pc_next=0000, freeze=0, flush=0.
- Stall vs branch: stall=1, br_taken=1, br_target=0041, imem_valid=1 -> pc_next=0040, freeze=0, flush=1.
- Pending redirect:
  - Stimulus: imem_valid=0 for 3 cycles; br_taken with target 1230 in cycle 2; imem_valid=1 in cycle 4.
  - Response: freeze=1 in cycles 1-3; cycle 4 gives pc_next=1230, flush=1; redir_pend cleared.
- Halt: halt_dec in RUN -> freeze=1 and flush=1 that cycle; halted=1 and fetch_req=0 from the next cycle. br_taken later is ignored. rst returns to BOOT.
- Reset mid-WAIT with a redirect pending -> redir_pend=0. After release, pc_next=RESET_PC and no spurious flush after the BOOT cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: sequencer state encoding, PC width,
// reset vector, sequential step and the redirect alignment mask.
package cpu_pkg;

  localparam int unsigned PC_WIDTH = 16;

  localparam logic [PC_WIDTH-1:0] RESET_PC   = 16'h0000;
  localparam logic [PC_WIDTH-1:0] PC_STEP    = 16'd2;
  // Instructions are halfword aligned, so redirect targets drop bit 0.
  localparam logic [PC_WIDTH-1:0] REDIR_MASK = 16'hFFFE;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StWait,
    StHalt
  } seq_state_e;

endpackage

// File: rtl/pc_incr.sv
// Sequential PC incrementer: adds PC_STEP and wraps mod 2^PC_WIDTH.
// Ports:
//   pc      - current PC
//   pc_inc  - pc + PC_STEP (FFFE wraps to 0000)
module pc_incr
  import cpu_pkg::*;
(
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_inc
);

  // Carry out is discarded on purpose to get the wrap.
  assign pc_inc = pc + PC_STEP;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage. Arbitrates halt, branch redirect,
// hazard stall, instruction-memory wait and sequential increment; flushes the
// IF/ID latch when a fetched word must be discarded. A redirect seen while
// memory is busy is held and applied in the cycle the fetch completes.
// Ports:
//   clk, rst    - clock (rising edge), asynchronous active-low reset
//   pc_cur      - current PC register value
//   imem_valid  - instruction memory returned the word at pc_cur
//   stall       - hazard unit requests PC hold
//   br_taken    - branch/jump resolved taken, target on br_target
//   br_target   - redirect address (bit 0 ignored)
//   halt_dec    - HLT opcode decoded
//   pc_next     - PC register data input
//   pc_freeze   - PC register write inhibit (1 = hold)
//   flush       - squash IF/ID latch at next edge
//   fetch_req   - instruction memory read request for pc_cur
//   halted      - core stopped
module pc_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_cur,
  input  logic                imem_valid,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                halt_dec,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                pc_freeze,
  output logic                flush,
  output logic                fetch_req,
  output logic                halted
);

  seq_state_e          state_q, state_d;
  logic                redir_pend_q, redir_pend_d;
  logic [PC_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] br_aligned;

  pc_incr u_pc_incr (
    .pc     (pc_cur),
    .pc_inc (pc_seq)
  );

  assign br_aligned = br_target & REDIR_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StBoot;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    // Hold is the safe default; pc_next is don't-care while frozen.
    pc_next      = pc_cur;
    pc_freeze    = 1'b1;
    flush        = 1'b0;
    fetch_req    = 1'b0;
    halted       = 1'b0;

    unique case (state_q)
      StBoot: begin
        pc_next   = RESET_PC;
        pc_freeze = 1'b0;
        flush     = 1'b1;
        state_d   = StRun;
      end

      StRun: begin
        fetch_req = 1'b1;
        if (halt_dec) begin
          flush        = 1'b1;
          redir_pend_d = 1'b0;
          state_d      = StHalt;
        end else if (br_taken) begin
          if (imem_valid) begin
            pc_next   = br_aligned;
            pc_freeze = 1'b0;
            flush     = 1'b1;
          end else begin
            // Fetch still outstanding: park the target until it lands.
            redir_pc_d   = br_aligned;
            redir_pend_d = 1'b1;
            state_d      = StWait;
          end
        end else if (stall) begin
          // Hold in RUN; a stalled fetch is simply reissued.
        end else if (!imem_valid) begin
          state_d = StWait;
        end else begin
          pc_next   = pc_seq;
          pc_freeze = 1'b0;
        end
      end

      StWait: begin
        fetch_req = 1'b1;
        if (halt_dec) begin
          flush        = 1'b1;
          redir_pend_d = 1'b0;
          state_d      = StHalt;
        end else if (!imem_valid) begin
          if (br_taken) begin
            redir_pc_d   = br_aligned;
            redir_pend_d = 1'b1;
          end
        end else begin
          state_d      = StRun;
          redir_pend_d = 1'b0;
          // A fresh branch this cycle beats the parked one.
          if (br_taken) begin
            pc_next   = br_aligned;
            pc_freeze = 1'b0;
            flush     = 1'b1;
          end else if (redir_pend_q) begin
            pc_next   = redir_pc_q;
            pc_freeze = 1'b0;
            flush     = 1'b1;
          end else if (!stall) begin
            pc_next   = pc_seq;
            pc_freeze = 1'b0;
          end
        end
      end

      StHalt: begin
        halted = 1'b1;
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by randomized traffic,
// all compared against a flag-based reference model of the sequencing rules.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] pc_cur;
  logic        imem_valid;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halt_dec;
  logic [15:0] pc_next;
  logic        pc_freeze;
  logic        flush;
  logic        fetch_req;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit          m_boot;
  bit          m_halted;
  bit          m_waiting;
  bit          m_pend;
  logic [15:0] m_pend_pc;
  int          halt_age;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .pc_cur     (pc_cur),
    .imem_valid (imem_valid),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halt_dec   (halt_dec),
    .pc_next    (pc_next),
    .pc_freeze  (pc_freeze),
    .flush      (flush),
    .fetch_req  (fetch_req),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot    = 1;
    m_halted  = 0;
    m_waiting = 0;
    m_pend    = 0;
    m_pend_pc = 16'h0000;
  endtask

  // Expected outputs from the model state plus current inputs.
  task automatic compare_outputs(input string tag);
    logic [15:0] e_next;
    bit e_frz, e_flush, e_req, e_halt, pc_chk, redir;
    logic [15:0] tgt;
    e_next = 16'h0; e_frz = 1; e_flush = 0; e_req = 0; e_halt = 0; pc_chk = 0;
    if (!rst || m_boot) begin
      e_next = 16'h0000; e_frz = 0; e_flush = 1; pc_chk = 1;
    end else if (m_halted) begin
      e_halt = 1;
    end else begin
      e_req = 1;
      redir = br_taken || (m_waiting && m_pend);
      tgt   = br_taken ? (br_target & 16'hFFFE) : m_pend_pc;
      if (halt_dec) e_flush = 1;
      else if (m_waiting && !imem_valid) e_frz = 1;
      else if (redir && imem_valid) begin
        e_next = tgt; e_frz = 0; e_flush = 1; pc_chk = 1;
      end else if (br_taken || stall || !imem_valid) e_frz = 1;
      else begin
        e_next = 16'((32'(pc_cur) + 2) % 65536); e_frz = 0; pc_chk = 1;
      end
    end
    check_eq({tag, ".freeze"}, 32'(pc_freeze), 32'(e_frz));
    check_eq({tag, ".flush"}, 32'(flush), 32'(e_flush));
    check_eq({tag, ".fetch_req"}, 32'(fetch_req), 32'(e_req));
    check_eq({tag, ".halted"}, 32'(halted), 32'(e_halt));
    if (pc_chk) check_eq({tag, ".pc_next"}, 32'(pc_next), 32'(e_next));
    check_eq({tag, ".redir_pend"}, 32'(dut.redir_pend_q), 32'(m_pend));
    if (m_pend) check_eq({tag, ".redir_pc"}, 32'(dut.redir_pc_q), 32'(m_pend_pc));
  endtask

  // State advance at the rising edge, using this cycle's inputs.
  task automatic model_step();
    if (!rst) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halted) begin
      // Only reset leaves HALT.
    end else if (halt_dec) begin
      m_halted = 1; m_pend = 0; m_waiting = 0;
    end else if (m_waiting) begin
      if (imem_valid) begin
        m_waiting = 0; m_pend = 0;
      end else if (br_taken) begin
        m_pend = 1; m_pend_pc = br_target & 16'hFFFE;
      end
    end else begin
      if (br_taken && !imem_valid) begin
        m_waiting = 1; m_pend = 1; m_pend_pc = br_target & 16'hFFFE;
      end else if (!br_taken && !stall && !imem_valid) begin
        m_waiting = 1;
      end
    end
  endtask

  // Inputs are set just after a rising edge; check at the falling edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    compare_outputs(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input bit v, input bit s, input bit b, input logic [15:0] t,
                        input bit h, input logic [15:0] pc);
    imem_valid = v; stall = s; br_taken = b; br_target = t; halt_dec = h; pc_cur = pc;
  endtask

  initial begin
    rst = 0;
    model_reset();
    set_in(1, 0, 0, 16'h0, 0, 16'h0000);

    // Reset and boot.
    #1;
    check_eq("rst.pc_next", 32'(pc_next), 32'h0000);
    check_eq("rst.flush", 32'(flush), 32'd1);
    check_eq("rst.fetch_req", 32'(fetch_req), 32'd0);
    cycle("rst");
    cycle("rst");
    rst = 1;
    cycle("boot");
    #1;
    check_eq("run0.pc_next", 32'(pc_next), 32'h0002);
    check_eq("run0.freeze", 32'(pc_freeze), 32'd0);
    cycle("run0");

    // Wrap.
    set_in(1, 0, 0, 16'h0, 0, 16'hFFFE);
    #1;
    check_eq("wrap.pc_next", 32'(pc_next), 32'h0000);
    check_eq("wrap.flush", 32'(flush), 32'd0);
    cycle("wrap");

    // Branch beats stall.
    set_in(1, 1, 1, 16'h0041, 0, 16'h0100);
    #1;
    check_eq("stbr.pc_next", 32'(pc_next), 32'h0040);
    check_eq("stbr.freeze", 32'(pc_freeze), 32'd0);
    check_eq("stbr.flush", 32'(flush), 32'd1);
    cycle("stbr");

    // Pending redirect across a three-cycle memory wait.
    set_in(0, 0, 0, 16'h0, 0, 16'h0040);
    #1; check_eq("pend1.freeze", 32'(pc_freeze), 32'd1);
    cycle("pend1");
    set_in(0, 0, 1, 16'h1230, 0, 16'h0040);
    #1; check_eq("pend2.freeze", 32'(pc_freeze), 32'd1);
    cycle("pend2");
    set_in(0, 0, 0, 16'h0, 0, 16'h0040);
    #1; check_eq("pend3.freeze", 32'(pc_freeze), 32'd1);
    cycle("pend3");
    set_in(1, 0, 0, 16'h0, 0, 16'h0040);
    #1;
    check_eq("pend4.pc_next", 32'(pc_next), 32'h1230);
    check_eq("pend4.flush", 32'(flush), 32'd1);
    check_eq("pend4.freeze", 32'(pc_freeze), 32'd0);
    cycle("pend4");
    check_eq("pend5.redir_pend", 32'(dut.redir_pend_q), 32'd0);

    // Halt, then a late branch that must be ignored.
    set_in(1, 0, 0, 16'h0, 1, 16'h1230);
    #1;
    check_eq("halt.freeze", 32'(pc_freeze), 32'd1);
    check_eq("halt.flush", 32'(flush), 32'd1);
    cycle("halt");
    set_in(1, 0, 1, 16'h5550, 0, 16'h1230);
    #1;
    check_eq("halted.halted", 32'(halted), 32'd1);
    check_eq("halted.fetch_req", 32'(fetch_req), 32'd0);
    cycle("halted");
    cycle("halted2");
    rst = 0;
    #1;
    check_eq("halt_rst.halted", 32'(halted), 32'd0);
    check_eq("halt_rst.pc_next", 32'(pc_next), 32'h0000);
    cycle("halt_rst");
    rst = 1;
    cycle("boot2");

    // Reset in WAIT with a redirect pending.
    set_in(0, 0, 0, 16'h0, 0, 16'h0200);
    cycle("wr1");
    set_in(0, 0, 1, 16'h0AB3, 0, 16'h0200);
    cycle("wr2");
    check_eq("wr.pend_set", 32'(dut.redir_pend_q), 32'd1);
    #2 rst = 0;
    #1;
    check_eq("wr.pend_clr", 32'(dut.redir_pend_q), 32'd0);
    check_eq("wr.pc_next", 32'(pc_next), 32'h0000);
    model_reset();
    cycle("wr_rst");
    rst = 1;
    set_in(1, 0, 0, 16'h0, 0, 16'h0000);
    cycle("wr_boot");
    #1;
    check_eq("wr_run.flush", 32'(flush), 32'd0);
    check_eq("wr_run.pc_next", 32'(pc_next), 32'h0002);
    cycle("wr_run");

    // Randomized traffic.
    halt_age = 0;
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0, 16'($urandom), $urandom_range(0, 49) == 0,
             16'($urandom));
      halt_age = m_halted ? halt_age + 1 : 0;
      rst = !($urandom_range(0, 199) == 0 || halt_age > 8);
      cycle("rand");
    end
    rst = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
